// File: rtl/gen_register_pkg.sv
// rtl/gen_register_pkg.sv - shared constants and command-conflict helper for gen_register
package gen_register_pkg;

   localparam int BUS_WIDTH_DEFAULT = 16;
   localparam int MODE_WRAP         = 0;
   localparam int MODE_SAT          = 1;

   // True when more than one of {clr, load, inc, dec} is asserted.
   function automatic logic cmd_conflict(input logic [3:0] cmd);
      logic [2:0] n;
      n = '0;
      for (int i = 0; i < 4; i++) begin
         n = n + {2'b00, cmd[i]};
      end
      return n > 3'd1;
   endfunction

endpackage

// File: rtl/gen_register_incdec.sv
// rtl/gen_register_incdec.sv - ripple increment/decrement chains with boundary flag
module gen_register_incdec #(
   parameter int WIDTH = 12
) (
   input  logic [WIDTH-1:0] value_i,
   input  logic             dir_i,
   output logic [WIDTH-1:0] next_o,
   output logic             bound_o
);

   // dir_i = 0: bit i toggles when all lower bits are 1; dir_i = 1: when all lower bits are 0.
   always_comb begin
      logic run;
      run    = 1'b1;
      next_o = '0;
      for (int i = 0; i < WIDTH; i++) begin
         next_o[i] = value_i[i] ^ run;
         run       = run & (value_i[i] ^ dir_i);
      end
      bound_o = run;
   end

endmodule

// File: rtl/gen_register.sv
// rtl/gen_register.sv - parametrised load/inc/dec/clr datapath register with status flags
module gen_register
   import gen_register_pkg::*;
#(
   parameter int                   WIDTH     = 12,
   parameter int                   BUS_WIDTH = BUS_WIDTH_DEFAULT,
   parameter int                   SATURATE  = MODE_WRAP,
   parameter logic [BUS_WIDTH-1:0] RESET_VAL = '0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 load,
   input  logic                 inc,
   input  logic                 dec,
   input  logic                 clr,
   input  logic                 err_clr,
   input  logic [BUS_WIDTH-1:0] indata,
   output logic [WIDTH-1:0]     outdata,
   output logic                 zero,
   output logic                 carry,
   output logic                 err
);

   logic [WIDTH-1:0] value_q, value_d;
   logic             carry_q, carry_d;
   logic             err_q, err_d;
   logic [WIDTH-1:0] step_value;
   logic             step_bound;

   gen_register_incdec #(.WIDTH(WIDTH)) u_incdec (
      .value_i (value_q),
      .dir_i   (dec),
      .next_o  (step_value),
      .bound_o (step_bound)
   );

   generate
      if (WIDTH < BUS_WIDTH) begin : g_unused
         logic unused_bus;
         assign unused_bus = ^indata[BUS_WIDTH-1:WIDTH];
      end
   endgenerate

   always_comb begin
      value_d = value_q;
      carry_d = 1'b0;
      err_d   = err_q;
      if (clr) begin
         value_d = RESET_VAL[WIDTH-1:0];
      end else if (load) begin
         value_d = indata[WIDTH-1:0];
      end else if (inc ^ dec) begin
         // An attempted overflow/underflow pulses carry even when saturating holds the value.
         carry_d = step_bound;
         if (!(SATURATE == MODE_SAT && step_bound)) begin
            value_d = step_value;
         end
      end
      if (cmd_conflict({clr, load, inc, dec})) begin
         err_d = 1'b1;
      end else if (err_clr) begin
         err_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         value_q <= RESET_VAL[WIDTH-1:0];
         carry_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         value_q <= value_d;
         carry_q <= carry_d;
         err_q   <= err_d;
      end
   end

   assign outdata = value_q;
   assign zero    = (value_q == '0);
   assign carry   = carry_q;
   assign err     = err_q;

endmodule

// File: doc/gen_register.md
Name: gen_register

Overview:
- Parametrised general-purpose data/address register for the basic computer datapath.
- Loads from the 16-bit common bus. Increments or decrements in place. Clears.
- Drives zero, carry/borrow and command-conflict status to the control unit.
- Replaces fixed-width load/inc/clr registers (AR, PC, DR, AC, TR) with one block.

Parameters:
- WIDTH, 12, stored register width. Legal range 1..BUS_WIDTH.
- BUS_WIDTH, 16, width of the common bus input.
- SATURATE, 0, boundary mode. 0 = wrap-around; 1 = hold at all-ones on inc and at zero on dec.
- RESET_VAL, 0, value loaded on reset and on clr. Only WIDTH LSBs are used.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- load  input  1  load indata[WIDTH-1:0] into the register.
- inc  input  1  increment the register by 1.
- dec  input  1  decrement the register by 1.
- clr  input  1  set the register to RESET_VAL.
- err_clr  input  1  clear the sticky err flag.
- indata  input  BUS_WIDTH  common bus value. Bits above WIDTH-1 are ignored.
- outdata  output  WIDTH  current register contents.
- zero  output  1  combinational; high when outdata == 0.
- carry  output  1  registered one-cycle pulse on overflow or underflow.
- err  output  1  sticky flag: conflicting command seen.

Behaviour:
- Reset (rst_n low at a rising edge): outdata = RESET_VAL, carry = 0, err = 0. Reset overrides every other input, including mid-operation.
- Command priority, evaluated each rising edge with rst_n high:
  1. clr: outdata <= RESET_VAL.
  2. else load: outdata <= indata[WIDTH-1:0].
  3. else inc and dec together: hold.
  4. else inc: outdata <= outdata + 1.
  5. else dec: outdata <= outdata - 1.
  6. else hold.
- Conflict: two or more of {clr, load, inc, dec} high in the same cycle. err is set on the next edge. The priority result above is still applied.
- err stays set until err_clr or reset. If err_clr and a new conflict occur in the same cycle, set wins.
- Latency: one cycle for every command. outdata reflects the command after the rising edge. zero follows outdata combinationally.
- Arithmetic: unsigned, modulo 2^WIDTH.
  - Increment uses a ripple AND-chain: bit i toggles when all lower bits are 1.
  - Decrement uses the mirror chain: bit i toggles when all lower bits are 0.
- Boundary, SATURATE=0:
  - inc at all-ones gives 0, with carry = 1 for exactly one cycle.
  - dec at 0 gives all-ones, with carry = 1 for exactly one cycle.
- Boundary, SATURATE=1:
  - inc at all-ones and dec at 0 leave the value unchanged.
  - carry still pulses for one cycle to flag the attempted overflow or underflow.
- carry is 0 in every other cycle, including after clr, load, hold, and inc+dec together.
- WIDTH == BUS_WIDTH: the whole bus is loaded. WIDTH == 1: inc and dec both toggle the bit.
- No X propagation: at any time after the first reset, all outputs are known.

Decomposition:
- Shared package gen_register_pkg holds:
  - BUS_WIDTH_DEFAULT = 16.
  - Boundary-mode constants MODE_WRAP = 0 and MODE_SAT = 1.
  - A function computing the conflict condition (population count of the command bits > 1).
- One sub-module, gen_register_incdec (combinational):
  - Inputs: WIDTH-bit value, direction.
  - Outputs: next value and boundary flag.
  - Contains both ripple chains.
- gen_register instantiates gen_register_incdec and holds the WIDTH-bit state, the carry flop and the err flop.

Test Plan:
- Reset: WIDTH=12, rst_n low for 1 edge, then high -> outdata = 0x000, zero = 1, carry = 0, err = 0.
- Load and ripple: load with indata = 0xF0FF, then inc -> outdata = 0x0FF, then 0x100, carry = 0.
- Wrap, SATURATE=0, WIDTH=12:
  - load 0xFFF, then inc -> outdata = 0x000, zero = 1, carry = 1 for one cycle only.
  - dec -> outdata = 0xFFF, carry = 1 for one cycle.
- Saturate, SATURATE=1, WIDTH=8:
  - load 0xFF, inc twice -> outdata stays 0xFF, carry pulses each cycle.
  - load 0, dec -> outdata stays 0x00.
- Conflict, WIDTH=12:
  - outdata = 0x005; load with indata = 0x123 and inc together -> outdata = 0x123, err = 1.
  - err still 1 after 3 idle cycles; err_clr -> err = 0.
  - clr with load -> outdata = RESET_VAL, err = 1.
- Reset mid-operation:
  - inc held high for 5 cycles from 0, then rst_n low during the 6th -> outdata = RESET_VAL, err = 0, carry = 0 on that edge.
  - Counting resumes from RESET_VAL once rst_n is high.
